// File: rtl/maze_mem_scheduler.sv
// maze_mem_scheduler: arbitrates the maze cell memory between host cell access and solver neighbour scans
module maze_mem_scheduler #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_h_req,
    input  logic          i_h_we,
    input  logic [AW-1:0] i_h_row,
    input  logic [AW-1:0] i_h_col,
    input  logic          i_h_wdata,
    output logic          o_h_gnt,
    output logic          o_h_rvalid,
    output logic          o_h_rdata,
    input  logic          i_s_req,
    input  logic [AW-1:0] i_s_row,
    input  logic [AW-1:0] i_s_col,
    output logic          o_s_gnt,
    output logic          o_s_done,
    output logic [3:0]    o_s_moves,
    output logic          o_m_en,
    output logic          o_m_we,
    output logic [AW-1:0] o_m_row,
    output logic [AW-1:0] o_m_col,
    output logic          o_m_wdata,
    input  logic          i_m_rdata
);
    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;
    state_t        r_state, w_next;
    logic          r_pri;
    logic [1:0]    r_dir;
    logic [AW-1:0] r_row, r_col;
    logic [2:0]    r_acc;
    logic          r_inb;
    logic [3:0]    r_s_moves;
    logic          r_s_done;
    logic          r_h_rvalid;
    logic          w_idle, w_scan, w_h_gnt, w_s_gnt, w_inb, w_bit;
    logic [AW:0]   w_nr, w_nc;
    assign w_idle  = (r_state == IDLE) && !i_rst;
    assign w_scan  = r_state == SCAN;
    assign w_h_gnt = w_idle && i_h_req && (!i_s_req || !r_pri);
    assign w_s_gnt = w_idle && i_s_req && (!i_h_req || r_pri);
    // one extra bit lets underflow (0-1) and overflow (N-1+1) both show up as >= N
    assign w_nr  = {1'b0, r_row} + ((r_dir == 2'd0) ? {(AW+1){1'b1}} : (r_dir == 2'd2) ? (AW+1)'(1) : '0);
    assign w_nc  = {1'b0, r_col} + ((r_dir == 2'd3) ? {(AW+1){1'b1}} : (r_dir == 2'd1) ? (AW+1)'(1) : '0);
    assign w_inb = (w_nr < (AW+1)'(N)) && (w_nc < (AW+1)'(N));
    assign w_bit = r_inb & ~i_m_rdata;
    // state register
    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? IDLE : w_next;
    end
    // next state: a scan is four SCAN cycles plus one WAIT to collect the last read
    always_comb begin
        w_next = (r_state == IDLE) ? (w_s_gnt ? SCAN : IDLE) :
                 (r_state == SCAN) ? ((r_dir == 2'd3) ? WAIT : SCAN) : IDLE;
    end
    // outputs: host drives memory directly in its grant cycle, scans drive in-bounds neighbour reads
    always_comb begin
        o_h_gnt   = w_h_gnt;
        o_s_gnt   = w_s_gnt;
        o_m_en    = w_h_gnt || (w_scan && w_inb);
        o_m_we    = w_h_gnt && i_h_we;
        o_m_wdata = w_h_gnt && i_h_we && i_h_wdata;
        o_m_row   = w_h_gnt ? i_h_row : (w_scan && w_inb) ? w_nr[AW-1:0] : '0;
        o_m_col   = w_h_gnt ? i_h_col : (w_scan && w_inb) ? w_nc[AW-1:0] : '0;
    end
    // datapath: priority toggle, scan latch, move accumulation shifted in as reads return
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pri      <= 1'b0;
            r_dir      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_inb      <= 1'b0;
            r_s_moves  <= '0;
            r_s_done   <= 1'b0;
            r_h_rvalid <= 1'b0;
        end else begin
            r_h_rvalid <= w_h_gnt && !i_h_we;
            r_s_done   <= r_state == WAIT;
            if (w_h_gnt) r_pri <= 1'b1;
            else if (w_s_gnt) r_pri <= 1'b0;
            if (w_s_gnt) begin
                r_row <= i_s_row;
                r_col <= i_s_col;
                r_acc <= '0;
                r_dir <= '0;
            end
            if (w_scan) begin
                r_dir <= r_dir + 2'd1;
                r_inb <= w_inb;
                r_acc <= {w_bit, r_acc[2:1]};
            end
            if (r_state == WAIT) r_s_moves <= {w_bit, r_acc};
        end
    end
    assign o_h_rvalid = r_h_rvalid;
    assign o_h_rdata  = r_h_rvalid & i_m_rdata;
    assign o_s_done   = r_s_done;
    assign o_s_moves  = r_s_moves;
endmodule

// File: tb/tb_maze_mem_scheduler.sv
// tb_maze_mem_scheduler: directed and random checks of the maze memory scheduler against a grid model
module tb_maze_mem_scheduler;
    logic       clk = 0, rst = 1;
    logic       h_req = 0, h_we = 0, h_wdata = 0, s_req = 0;
    logic [3:0] h_row = 0, h_col = 0, s_row = 0, s_col = 0;
    logic       h_gnt, h_rvalid, h_rdata, s_gnt, s_done, m_en, m_we, m_wdata;
    logic [3:0] s_moves, m_row, m_col;
    logic       m_rdata = 0;
    logic       mem [16][16];
    bit         refm [16][16];
    int         cmp = 0, bad = 0;

    always #5 clk = ~clk;

    maze_mem_scheduler #(.N(16), .AW(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_h_req(h_req), .i_h_we(h_we), .i_h_row(h_row), .i_h_col(h_col),
        .i_h_wdata(h_wdata), .o_h_gnt(h_gnt), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata),
        .i_s_req(s_req), .i_s_row(s_row), .i_s_col(s_col), .o_s_gnt(s_gnt), .o_s_done(s_done),
        .o_s_moves(s_moves), .o_m_en(m_en), .o_m_we(m_we), .o_m_row(m_row), .o_m_col(m_col),
        .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
    );

    initial for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mem[r][c] = 1'b0;

    always @(posedge clk) if (m_en) begin
        if (m_we) mem[m_row][m_col] <= m_wdata;
        else m_rdata <= mem[m_row][m_col];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit inb(input int r, input int c, input int d);
        return d == 0 ? r > 0 : d == 1 ? c < 15 : d == 2 ? r < 15 : c > 0;
    endfunction

    function automatic int nbr(input int r, input int c, input int d);
        int nr = r + (d == 0 ? -1 : d == 2 ? 1 : 0);
        int nc = c + (d == 1 ? 1 : d == 3 ? -1 : 0);
        return nr * 16 + nc;
    endfunction

    function automatic logic [3:0] exp_moves(input int r, input int c);
        logic [3:0] m;
        for (int d = 0; d < 4; d++) begin
            int a = nbr(r, c, d);
            m[d] = inb(r, c, d) && !refm[a / 16][a % 16];
        end
        return m;
    endfunction

    task automatic wait_gnt(input bit host, output int n);
        n = 0;
        #1;
        while (!(host ? h_gnt : s_gnt) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk(host ? "h_gnt" : "s_gnt", host ? h_gnt : s_gnt, 1);
    endtask

    task automatic host_write(input int r, input int c, input bit d);
        int n;
        @(negedge clk); h_req = 1; h_we = 1; h_row = 4'(r); h_col = 4'(c); h_wdata = d;
        wait_gnt(1, n);
        chk("wr_m_en", m_en, 1); chk("wr_m_we", m_we, 1);
        chk("wr_addr", {m_row, m_col}, r * 16 + c); chk("wr_data", m_wdata, d);
        refm[r][c] = d;
        @(negedge clk); h_req = 0; h_we = 0;
    endtask

    task automatic host_read(input int r, input int c);
        int n;
        @(negedge clk); h_req = 1; h_we = 0; h_row = 4'(r); h_col = 4'(c);
        wait_gnt(1, n);
        chk("rd_m_en", m_en, 1); chk("rd_m_we", m_we, 0); chk("rd_addr", {m_row, m_col}, r * 16 + c);
        @(negedge clk); h_req = 0; #1;
        chk("rd_rvalid", h_rvalid, 1); chk("rd_data", h_rdata, refm[r][c]);
    endtask

    task automatic scan(input int r, input int c, input bit hold_h, input bit already, output int n);
        if (!already) begin
            @(negedge clk); s_req = 1; s_row = 4'(r); s_col = 4'(c);
        end
        wait_gnt(0, n);
        @(negedge clk); s_req = 0;
        if (hold_h) begin h_req = 1; h_we = 0; h_row = 0; h_col = 0; end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("scan_m_en", m_en, k < 4 ? inb(r, c, k) : 0);
            if (k < 4 && inb(r, c, k)) begin
                chk("scan_m_we", m_we, 0); chk("scan_addr", {m_row, m_col}, nbr(r, c, k));
            end
            chk("scan_s_done_early", s_done, 0);
            chk("scan_h_blocked", h_gnt, 0);
            @(negedge clk);
        end
        #1;
        chk("scan_s_done", s_done, 1);
        chk("scan_moves", s_moves, exp_moves(r, c));
        chk("scan_h_after", h_gnt, hold_h);
        if (hold_h) begin @(negedge clk); h_req = 0; end
    endtask

    initial begin
        int n;
        logic [9:0] hg, sg;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) refm[r][c] = 0;
        repeat (3) @(negedge clk);
        rst = 0; #1;
        chk("rst_h_gnt", h_gnt, 0); chk("rst_s_gnt", s_gnt, 0); chk("rst_m_en", m_en, 0);
        chk("rst_s_done", s_done, 0); chk("rst_moves", s_moves, 0); chk("rst_rvalid", h_rvalid, 0);
        // both requesters held: host, scan, then host again after the 6-cycle scan
        @(negedge clk); h_req = 1; h_we = 0; h_row = 0; h_col = 0; s_req = 1; s_row = 5; s_col = 5;
        for (int k = 0; k < 10; k++) begin
            #1; hg[k] = h_gnt; sg[k] = s_gnt;
            @(negedge clk);
        end
        h_req = 0; s_req = 0;
        chk("alt_h_gnts", hg, 10'b0010000001);
        chk("alt_s_gnts", sg, 10'b0100000010);
        repeat (8) @(negedge clk);
        scan(5, 5, 0, 0, n); chk("tp_open", s_moves, 4'b1111);
        scan(0, 0, 0, 0, n); chk("tp_corner00", s_moves, 4'b0110);
        scan(15, 15, 0, 0, n); chk("tp_corner1515", s_moves, 4'b1001);
        host_write(4, 5, 1);
        host_write(5, 6, 1);
        scan(5, 5, 1, 0, n); chk("tp_walls", s_moves, 4'b1100);
        // back-to-back host write then read of the same cell
        @(negedge clk); h_req = 1; h_we = 1; h_row = 3; h_col = 3; h_wdata = 1; #1;
        chk("b2b_wr_gnt", h_gnt, 1);
        refm[3][3] = 1;
        @(negedge clk); h_we = 0; #1;
        chk("b2b_rd_gnt", h_gnt, 1); chk("b2b_rd_we", m_we, 0);
        @(negedge clk); h_req = 0; #1;
        chk("b2b_rvalid", h_rvalid, 1); chk("b2b_rdata", h_rdata, 1);
        // reset at scan cycle T+3 aborts the scan
        @(negedge clk); s_req = 1; s_row = 5; s_col = 5;
        wait_gnt(0, n);
        @(negedge clk); s_req = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; s_req = 1; s_row = 2; s_col = 2; #1;
        chk("abort_moves", s_moves, 0); chk("abort_s_done", s_done, 0); chk("abort_m_en", m_en, 0);
        scan(2, 2, 0, 1, n); chk("abort_regrant_wait", n, 0);
        // random mix of host traffic and scans against the grid model
        for (int i = 0; i < 80; i++) begin
            int op = $urandom_range(0, 3);
            int r = $urandom_range(0, 15);
            int c = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) r = ($urandom_range(0, 1) != 0) ? 15 : 0;
            if (op <= 1) host_write(r, c, $urandom_range(0, 2) == 0);
            else if (op == 2) host_read(r, c);
            else scan(r, c, $urandom_range(0, 1) != 0, 0, n);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
